imem_loader: RTL and testbench

Byte-stream program loader that writes instruction memory for the single-cycle CPU. It receives a length-prefixed big-endian word stream over a valid/ready byte interface. It packs the bytes into 32-bit words and drives the instruction-memory write port. It holds the CPU in reset until the image is complete, then releases it, so the CPU's first fetch after release sees the loaded image.

---
 rtl/loader_pkg.sv | 22 ++
 rtl/imem_loader_byte_packer.sv | 51 +++++
 rtl/imem_loader.sv | 159 +++++++++++++++
 tb/tb_imem_loader.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package loader_pkg;

  localparam int unsigned HDR_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned CNT_W      = 8 * HDR_BYTES;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_e;

  // States in which the loader consumes stream bytes.
  function automatic logic accepts_bytes(input state_e s);
    return (s == HDR0) || (s == HDR1) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs big-endian data bytes into 32-bit words; pulses word_valid_o the cycle
// after the fourth byte of a word is accepted, with word_o holding that word.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        last_byte_c,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] shift_q, shift_d;
  logic        valid_q, valid_d;

  assign last_byte_c = byte_valid_i && (idx_q == 2'(WORD_BYTES - 1));

  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    if (clear_i) begin
      idx_d   = 2'd0;
      shift_d = 32'd0;
    end else if (byte_valid_i) begin
      shift_d = {shift_q[23:0], byte_i};
      idx_d   = idx_q + 2'd1;
      valid_d = last_byte_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= 2'd0;
      shift_q <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
    end
  end

  assign word_valid_o = valid_q;
  assign word_o       = shift_q;

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader for instruction memory; holds the CPU until
// the image is complete. Define LOADER_CHECKSUM_EN to require a trailing XOR byte.
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              pcrst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [CNT_W:0] DEPTH = {{CNT_W{1'b0}}, 1'b1} << ADDR_W;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        csum_q, csum_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              hold_q, hold_d;

  logic              accept_c;
  logic              reload_c;
  logic              pack_valid_c;
  logic              last_byte_c;
  logic              last_word_c;
  logic [CNT_W-1:0]  n_full_c;

  assign rx_ready     = accepts_bytes(state_q);
  assign accept_c     = rx_valid && rx_ready;
  assign pack_valid_c = accept_c && (state_q == DATA);
  assign n_full_c     = {n_q[CNT_W-1 -: 8], rx_data};
  assign last_word_c  = (CNT_W'(word_q) == (n_q - CNT_W'(1)));

  byte_packer u_packer (
    .clk          (clk),
    .rst_n        (pcrst),
    .clear_i      (reload_c),
    .byte_valid_i (pack_valid_c),
    .byte_i       (rx_data),
    .last_byte_c  (last_byte_c),
    .word_valid_o (imem_we),
    .word_o       (imem_wdata)
  );

  // Next-state, counter and checksum logic.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    word_d   = word_q;
    addr_d   = addr_q;
    csum_d   = csum_q;
    reload_c = 1'b0;
    case (state_q)
      HDR0: begin
        if (accept_c) begin
          n_d[CNT_W-1 -: 8] = rx_data;
          csum_d            = csum_q ^ rx_data;
          state_d           = HDR1;
        end
      end
      HDR1: begin
        if (accept_c) begin
          n_d    = n_full_c;
          csum_d = csum_q ^ rx_data;
          word_d = '0;
          if ({1'b0, n_full_c} > DEPTH) begin
            state_d = ERR;
          end else if (n_full_c == '0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept_c) begin
          csum_d = csum_q ^ rx_data;
        end
        if (last_byte_c) begin
          addr_d = word_q;
          word_d = word_q + ADDR_W'(1);
          if (last_word_c) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end
        end
      end
      CSUM: begin
        if (accept_c) begin
          state_d = (rx_data == csum_q) ? DONE : ERR;
        end
      end
      DONE, ERR: begin
        if (reload) begin
          state_d  = HDR0;
          n_d      = '0;
          word_d   = '0;
          csum_d   = 8'd0;
          reload_c = 1'b1;
        end
      end
      default: state_d = HDR0;
    endcase
  end

  // cpu_hold lags DONE by one edge so the final write lands before release.
  always_comb begin
    done_d = (state_d == DONE);
    err_d  = (state_d == ERR);
    hold_d = (state_q != DONE) || reload_c;
  end

  always_ff @(posedge clk or negedge pcrst) begin
    if (!pcrst) begin
      state_q <= HDR0;
      n_q     <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      csum_q  <= 8'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      csum_q  <= csum_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  assign imem_addr = addr_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cpu_hold  = hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a stream-position reference model.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 6;
  localparam int DEPTH = 1 << ADDR_W;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic              clk;
  logic              pcrst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              reload;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .pcrst      (pcrst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: tracks position in the byte stream and derives outputs from it.
  int          m_phase;  // 0 loading, 1 done, 2 error
  int          m_pos;
  int          m_n;
  logic [7:0]  m_csum;
  logic [31:0] m_wbuf;
  bit          m_we;
  int          m_addr;
  logic [31:0] m_data;
  bit          m_hold;

  always @(posedge clk or negedge pcrst) begin
    bit hold_next;
    logic [7:0] b;
    if (!pcrst) begin
      m_phase = 0; m_pos = 0; m_n = 0; m_csum = 8'd0; m_we = 0; m_hold = 1;
    end else begin
      hold_next = (m_phase != 1);
      m_we = 0;
      if (m_phase != 0) begin
        if (reload) begin
          m_phase = 0; m_pos = 0; m_csum = 8'd0; hold_next = 1;
        end
      end else if (rx_valid) begin
        b = rx_data;
        if (m_pos == 0) begin
          m_n = int'(b) * 256;
          m_csum ^= b;
        end else if (m_pos == 1) begin
          m_n += int'(b);
          m_csum ^= b;
          if (m_n > DEPTH) m_phase = 2;
          else if (m_n == 0 && !CSUM_ON) m_phase = 1;
        end else if (m_pos < 2 + 4 * m_n) begin
          m_csum ^= b;
          m_wbuf = {m_wbuf[23:0], b};
          if ((m_pos - 2) % 4 == 3) begin
            m_we = 1; m_addr = (m_pos - 2) / 4; m_data = m_wbuf;
          end
          if (m_pos == 2 + 4 * m_n - 1 && !CSUM_ON) m_phase = 1;
        end else begin
          m_phase = (b == m_csum) ? 1 : 2;
        end
        m_pos++;
      end
      m_hold = hold_next;
    end
  end

  // Per-cycle comparison of every output against the model.
  bit checking = 0;
  always @(negedge clk) begin
    if (checking) begin
      chk("rx_ready", 32'(rx_ready), 32'(m_phase == 0));
      chk("imem_we", 32'(imem_we), 32'(m_we));
      if (m_we && imem_we) begin
        chk("imem_addr", 32'(imem_addr), 32'(m_addr));
        chk("imem_wdata", imem_wdata, m_data);
      end
      chk("done", 32'(done), 32'(m_phase == 1));
      chk("err", 32'(err), 32'(m_phase == 2));
      chk("cpu_hold", 32'(cpu_hold), 32'(m_hold));
    end
  end

  // Simulated instruction memory and write log.
  logic [31:0] mem [DEPTH];
  logic [31:0] img [DEPTH];
  int wr_cnt = 0;
  int last_addr = -1;
  int cyc = 0;
  int we_cyc[$];

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (imem_we) begin
      mem[imem_addr] = imem_wdata;
      wr_cnt++;
      last_addr = int'(imem_addr);
      we_cyc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic put(input logic [7:0] b, input int gap);
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_image(input int n, input int maxgap, input bit good_csum, input int reload_at);
    logic [7:0]  q[$];
    logic [15:0] nn;
    logic [31:0] w;
    logic [7:0]  x;
    nn = 16'(n);
    q.push_back(nn[15:8]);
    q.push_back(nn[7:0]);
    for (int i = 0; i < n; i++) begin
      w = img[i];
      q.push_back(w[31:24]); q.push_back(w[23:16]); q.push_back(w[15:8]); q.push_back(w[7:0]);
    end
    x = 8'd0;
    foreach (q[i]) x ^= q[i];
    if (CSUM_ON) q.push_back(good_csum ? x : (x ^ 8'h03));
    foreach (q[i]) begin
      reload = (i == reload_at);
      put(q[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
    reload = 1'b0;
  endtask

  task automatic wait_end(input int budget, input string name);
    int k = 0;
    while (!(done || err) && k < budget) begin tick(1); k++; end
    if (!(done || err)) begin
      checks++;
      $display("FAIL %s: timeout after %0d cycles, got done=%b err=%b expected completion", name, budget, done, err);
    end
  endtask

  task automatic do_reload();
    reload = 1'b1; tick(1); reload = 1'b0;
  endtask

  task automatic check_image(input int n, input string name);
    for (int i = 0; i < n; i++) chk(name, mem[i], img[i]);
  endtask

  task automatic rand_img(input int n);
    for (int i = 0; i < n; i++) img[i] = $urandom;
  endtask

  initial begin
    int base;
    pcrst = 1'b0; rx_valid = 1'b0; rx_data = 8'd0; reload = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;

    repeat (2) @(posedge clk); #1;
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    checking = 1;
    pcrst = 1'b1;
    tick(1);

    // Directed two-word load at full rate.
    img[0] = 32'h12345678; img[1] = 32'h9ABCDEF0;
    wr_cnt = 0; we_cyc.delete();
    send_image(2, 0, 1'b1, -1);
    chk("n2_done", 32'(done), 32'd1);
    wait_end(20, "n2_wait");
    tick(2);
    chk("n2_writes", 32'(wr_cnt), 32'd2);
    if (we_cyc.size() == 2) chk("n2_spacing", 32'(we_cyc[1] - we_cyc[0]), 32'd4);
    chk("n2_mem0", mem[0], 32'h12345678);
    chk("n2_mem1", mem[1], 32'h9ABCDEF0);
    chk("n2_hold_released", 32'(cpu_hold), 32'd0);

    // Empty image.
    do_reload();
    wr_cnt = 0;
    send_image(0, 0, 1'b1, -1);
    wait_end(20, "n0_wait");
    tick(2);
    chk("n0_done", 32'(done), 32'd1);
    chk("n0_writes", 32'(wr_cnt), 32'd0);

    // Header overflow: 0x41 words into a 64-word memory.
    do_reload();
    wr_cnt = 0;
    put(8'h00, 0); put(8'h41, 0);
    chk("ovf_err", 32'(err), 32'd1);
    tick(3);
    chk("ovf_hold", 32'(cpu_hold), 32'd1);
    chk("ovf_writes", 32'(wr_cnt), 32'd0);

    // Reload out of ERR.
    do_reload();
    chk("rl_err", 32'(err), 32'd0);
    chk("rl_hold", 32'(cpu_hold), 32'd1);
    chk("rl_ready", 32'(rx_ready), 32'd1);

    // Full depth at full rate, then the same image with idle gaps.
    rand_img(DEPTH);
    wr_cnt = 0;
    send_image(DEPTH, 0, 1'b1, -1);
    wait_end(50, "full_wait");
    tick(2);
    chk("full_writes", 32'(wr_cnt), 32'(DEPTH));
    chk("full_last_addr", 32'(last_addr), 32'(DEPTH - 1));
    chk("full_done", 32'(done), 32'd1);
    check_image(DEPTH, "full_mem");
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
    do_reload();
    send_image(DEPTH, 3, 1'b1, -1);
    wait_end(50, "gap_wait");
    tick(2);
    check_image(DEPTH, "gap_mem");

    // Reload asserted mid-DATA must be ignored.
    do_reload();
    rand_img(4);
    send_image(4, 1, 1'b1, 7);
    wait_end(50, "rld_data_wait");
    tick(2);
    chk("rld_data_done", 32'(done), 32'd1);
    check_image(4, "rld_data_mem");

    // Reset after two bytes of a word: partial word never written.
    do_reload();
    base = wr_cnt;
    put(8'h00, 0); put(8'h01, 0); put(8'hDE, 0); put(8'hAD, 0);
    pcrst = 1'b0;
    tick(2);
    pcrst = 1'b1;
    tick(2);
    chk("abort_writes", 32'(wr_cnt - base), 32'd0);
    chk("abort_hold", 32'(cpu_hold), 32'd1);
    rand_img(3);
    send_image(3, 2, 1'b1, -1);
    wait_end(50, "abort_reload_wait");
    tick(2);
    chk("abort_writes_after", 32'(wr_cnt - base), 32'd3);
    check_image(3, "abort_mem");

    if (CSUM_ON) begin
      do_reload();
      img[0] = 32'hA5A5A5A5;
      send_image(1, 0, 1'b1, -1);
      tick(2);
      chk("csum_ok_done", 32'(done), 32'd1);
      chk("csum_ok_mem", mem[0], 32'hA5A5A5A5);
      do_reload();
      send_image(1, 0, 1'b0, -1);
      tick(2);
      chk("csum_bad_err", 32'(err), 32'd1);
      chk("csum_bad_hold", 32'(cpu_hold), 32'd1);
    end

    // Random loads.
    for (int t = 0; t < 6; t++) begin
      int n;
      bit good;
      do_reload();
      n = int'($urandom_range(1, 8));
      good = ($urandom_range(0, 3) != 0);
      rand_img(n);
      send_image(n, 2, good, -1);
      wait_end(50, "rand_wait");
      tick(2);
      check_image(n, "rand_mem");
    end

    checking = 0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
